wb_demux: RTL and testbench

WB_DEMUX -- requirements
Module: wb_demux

---
 rtl/wb_demux_pkg.sv | 20 ++
 rtl/wb_demux_slot.sv | 39 +++
 rtl/wb_demux.sv | 80 ++++++++
 tb/tb_wb_demux.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_demux_pkg.sv
// Shared widths, port-select encodings and the write-request record for wb_demux.
package wb_demux_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_PORTS = 2;

  localparam logic SEL_PORT0 = 1'b0;
  localparam logic SEL_PORT1 = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
    return (a == '0);
  endfunction

endpackage

// File: rtl/wb_demux_slot.sv
// One output slot: a valid flag plus the buffered address/data of a single write.
module wb_demux_slot
  import wb_demux_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // Load wins over drain so a same-edge drain+refill keeps the slot full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule

// File: rtl/wb_demux.sv
// One-to-two write demux with a single-entry slot per output port.
// Build option: WB_DEMUX_ZERO_DROP_EN discards address-0 writes instead of delivering them.
module wb_demux
  import wb_demux_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [ADDR_W-1:0] out0_addr,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [ADDR_W-1:0] out1_addr,
  output logic [DATA_W-1:0] out1_data
);

  logic [NUM_PORTS-1:0] w_slot_valid;
  logic [NUM_PORTS-1:0] w_out_ready;
  logic [NUM_PORTS-1:0] w_slot_ready;
  logic [NUM_PORTS-1:0] w_load;
  logic [NUM_PORTS-1:0] w_drain;
  logic                 w_sel_ready;
  logic                 w_drop;
  logic                 w_accept;
  wr_req_t              w_req;

  assign w_out_ready  = {out1_ready, out0_ready};
  // A slot can take a new write if empty or being emptied on this edge.
  assign w_slot_ready = ~w_slot_valid | w_out_ready;
  assign w_sel_ready  = w_slot_ready[in_sel];

`ifdef WB_DEMUX_ZERO_DROP_EN
  assign w_drop = in_valid & is_zero_addr(in_addr);
`else
  assign w_drop = 1'b0;
`endif

  assign in_ready = w_sel_ready | w_drop;
  assign w_accept = in_valid & in_ready & ~w_drop;

  assign w_load[0] = w_accept & (in_sel == SEL_PORT0);
  assign w_load[1] = w_accept & (in_sel == SEL_PORT1);
  assign w_drain   = w_slot_valid & w_out_ready;

  assign w_req = '{addr: in_addr, data: in_data};

  wb_demux_slot u_slot0 (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load[0]),
    .i_drain (w_drain[0]),
    .i_addr  (w_req.addr),
    .i_data  (w_req.data),
    .o_valid (w_slot_valid[0]),
    .o_addr  (out0_addr),
    .o_data  (out0_data)
  );

  wb_demux_slot u_slot1 (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load[1]),
    .i_drain (w_drain[1]),
    .i_addr  (w_req.addr),
    .i_data  (w_req.data),
    .o_valid (w_slot_valid[1]),
    .o_addr  (out1_addr),
    .o_data  (out1_data)
  );

  assign out0_valid = w_slot_valid[0];
  assign out1_valid = w_slot_valid[1];

endmodule

// File: tb/tb_wb_demux.sv
// Directed and randomized checks of wb_demux against a queue-based port model.
module tb_wb_demux;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_sel;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [4:0]  out0_addr, out1_addr;
  logic [31:0] out0_data, out1_data;

  int errors = 0;
  int checks = 0;

`ifdef WB_DEMUX_ZERO_DROP_EN
  localparam bit DROP0 = 1'b1;
`else
  localparam bit DROP0 = 1'b0;
`endif

  wb_demux dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_addr(in_addr), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out0_addr(out0_addr), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out1_addr(out1_addr), .out1_data(out1_data)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drain_all();
    in_valid = 0; out0_ready = 1; out1_ready = 1;
    tick();
    out0_ready = 0; out1_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; in_sel = 0; in_addr = 0; in_data = 0;
    out0_ready = 0; out1_ready = 0;
    repeat (2) tick();
    chk("reset_out0_valid", 37'(out0_valid), 37'd0);
    chk("reset_out1_valid", 37'(out1_valid), 37'd0);
    chk("reset_out0_ad", {out0_addr, out0_data}, 37'd0);
    chk("reset_out1_ad", {out1_addr, out1_data}, 37'd0);
    @(negedge clk); reset = 0;
    #1;
    in_sel = 0; #1; chk("ready_after_reset_sel0", 37'(in_ready), 37'd1);
    in_sel = 1; #1; chk("ready_after_reset_sel1", 37'(in_ready), 37'd1);
    tick();
  endtask

  task automatic test_single();
    in_valid = 1; in_sel = 0; in_addr = 5'd3; in_data = 32'h12345678;
    #1 chk("single_in_ready", 37'(in_ready), 37'd1);
    tick();
    in_valid = 0;
    chk("single_out0_valid", 37'(out0_valid), 37'd1);
    chk("single_out0_ad", {out0_addr, out0_data}, {5'd3, 32'h12345678});
    chk("single_out1_valid", 37'(out1_valid), 37'd0);
    drain_all();
    chk("single_drained", 37'(out0_valid), 37'd0);
  endtask

  task automatic test_backpressure();
    in_valid = 1; in_sel = 1; in_addr = 5'd7; in_data = 32'hCAFE0001;
    tick();
    in_addr = 5'd8; in_data = 32'h11112222;
    #1 chk("bp_sel1_not_ready", 37'(in_ready), 37'd0);
    tick();
    chk("bp_out1_valid", 37'(out1_valid), 37'd1);
    chk("bp_out1_held", {out1_addr, out1_data}, {5'd7, 32'hCAFE0001});
    in_sel = 0; in_addr = 5'd9; in_data = 32'h33334444;
    #1 chk("bp_sel0_ready", 37'(in_ready), 37'd1);
    tick();
    in_valid = 0;
    chk("bp_out0_ad", {out0_addr, out0_data}, {5'd9, 32'h33334444});
    chk("bp_out1_still_held", {out1_addr, out1_data}, {5'd7, 32'hCAFE0001});
    drain_all();
    chk("bp_both_drained", {35'd0, out1_valid, out0_valid}, 37'd0);
  endtask

  task automatic test_drain_refill();
    in_valid = 1; in_sel = 0; in_addr = 5'd1; in_data = 32'hAAAA0000;
    tick();
    out0_ready = 1; in_addr = 5'd2; in_data = 32'h5555FFFF;
    #1 chk("refill_in_ready", 37'(in_ready), 37'd1);
    tick();
    in_valid = 0; out0_ready = 0;
    chk("refill_valid_kept", 37'(out0_valid), 37'd1);
    chk("refill_new_ad", {out0_addr, out0_data}, {5'd2, 32'h5555FFFF});
    drain_all();
  endtask

  task automatic test_reset_mid();
    in_valid = 1; in_sel = 0; in_addr = 5'd4; in_data = 32'h0BADF00D;
    tick();
    in_sel = 1; in_addr = 5'd5; in_data = 32'hFEEDFACE;
    tick();
    in_valid = 0;
    chk("rmid_full", {35'd0, out1_valid, out0_valid}, 37'd3);
    #2 reset = 1;
    #1;
    chk("rmid_valids", {35'd0, out1_valid, out0_valid}, 37'd0);
    chk("rmid_out0_ad", {out0_addr, out0_data}, 37'd0);
    chk("rmid_out1_ad", {out1_addr, out1_data}, 37'd0);
    @(negedge clk); reset = 0;
    tick();
  endtask

  task automatic test_addr0();
    in_valid = 1; in_sel = 1; in_addr = 5'd0; in_data = 32'hDEADBEEF;
    #1 chk("a0_in_ready", 37'(in_ready), 37'd1);
    tick();
    in_valid = 0;
    if (DROP0) begin
      chk("a0_dropped_empty", 37'(out1_valid), 37'd0);
      in_valid = 1; in_addr = 5'd4; in_data = 32'h01020304;
      tick();
      in_addr = 5'd0; in_data = 32'hDEADBEEF;
      #1 chk("a0_forced_ready", 37'(in_ready), 37'd1);
      tick();
      in_valid = 0;
      chk("a0_full_unchanged", {out1_valid, out1_addr, out1_data[30:0]}, {1'b1, 5'd4, 31'h01020304});
    end else begin
      chk("a0_out1_valid", 37'(out1_valid), 37'd1);
      chk("a0_out1_ad", {out1_addr, out1_data}, {5'd0, 32'hDEADBEEF});
    end
    chk("a0_out0_untouched", 37'(out0_valid), 37'd0);
    drain_all();
  endtask

  task automatic test_stream();
    logic [36:0] pend[2][$];
    logic [36:0] acc[2][$];
    logic [36:0] got[2][$];
    logic [36:0] front;
    bit rdy[2];
    bit exp_ready, drop;
    int n_acc = 0;
    int cyc = 0;
    while (n_acc < 100 || pend[0].size() != 0 || pend[1].size() != 0) begin
      if (cyc >= 3000) begin
        errors++;
        $display("FAIL stream_timeout: accepted %0d of 100", n_acc);
        break;
      end
      in_valid = (n_acc < 100) && ($urandom_range(3) != 0);
      in_sel = 1'($urandom);
      in_addr = 5'($urandom_range(3) == 0 ? 0 : $urandom);
      in_data = $urandom;
      out0_ready = (n_acc >= 100) || ($urandom_range(2) != 0);
      out1_ready = (n_acc >= 100) || ($urandom_range(2) != 0);
      rdy[0] = out0_ready; rdy[1] = out1_ready;
      #1;
      drop = DROP0 && in_valid && (in_addr == 0);
      exp_ready = (pend[in_sel].size() == 0) || rdy[in_sel] || drop;
      chk("stream_in_ready", 37'(in_ready), 37'(exp_ready));
      chk("stream_valids", {35'd0, out1_valid, out0_valid},
          {35'd0, pend[1].size() != 0, pend[0].size() != 0});
      for (int p = 0; p < 2; p++) begin
        if (pend[p].size() != 0) begin
          front = (p == 0) ? {out0_addr, out0_data} : {out1_addr, out1_data};
          chk("stream_out_ad", front, pend[p][0]);
          if (rdy[p]) begin
            got[p].push_back(front);
            void'(pend[p].pop_front());
          end
        end
      end
      if (in_valid && exp_ready && !drop) begin
        pend[in_sel].push_back({in_addr, in_data});
        acc[in_sel].push_back({in_addr, in_data});
      end
      if (in_valid && exp_ready) n_acc++;
      tick();
      cyc++;
    end
    in_valid = 0; out0_ready = 0; out1_ready = 0;
    for (int p = 0; p < 2; p++) begin
      chk("stream_count", 37'(got[p].size()), 37'(acc[p].size()));
      for (int i = 0; i < acc[p].size() && i < got[p].size(); i++)
        chk("stream_order", got[p][i], acc[p][i]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_drain_refill();
    test_reset_mid();
    test_addr0();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
